// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 subordinate backed by a word-addressed on-chip memory.
// One write burst and one read burst may be in flight at a time, independently.
// Supports FIXED/INCR/WRAP bursts, byte strobes, and DECERR/SLVERR responses.
module axi4_mem_responder #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 32,
   parameter int ID_WIDTH       = 30,
   parameter int MEM_DEPTH_LOG2 = 10
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic [1:0]              AWBURST,
   input  logic [ID_WIDTH-1:0]     AWID,
   input  logic                    WVALID,
   output logic                    WREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   output logic                    BVALID,
   input  logic                    BREADY,
   output logic [ID_WIDTH-1:0]     BID,
   output logic [1:0]              BRESP,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [1:0]              ARBURST,
   input  logic [ID_WIDTH-1:0]     ARID,
   output logic                    RVALID,
   input  logic                    RREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [ID_WIDTH-1:0]     RID,
   output logic [1:0]              RRESP,
   output logic                    RLAST
);
   localparam int BYTES     = DATA_WIDTH / 8;
   localparam int LSB       = $clog2(BYTES);
   localparam int MEM_WORDS = 1 << MEM_DEPTH_LOG2;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   w_state_t              w_state;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]            w_len;
   logic [1:0]            w_burst;
   logic [7:0]            w_beat;
   logic                  w_decerr;
   logic                  w_slverr;

   r_state_t              r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic [1:0]            r_burst;
   logic [7:0]            r_beat;
   logic [ADDR_WIDTH-1:0] r_next;

   logic                  w_fire;
   logic                  w_last_beat;
   logic                  beat_decerr;
   logic                  beat_slverr;

   // Address is decodable only when every bit above the memory window is zero.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      return addr[ADDR_WIDTH-1:LSB+MEM_DEPTH_LOG2] == '0;
   endfunction

   function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      return addr[LSB+MEM_DEPTH_LOG2-1:LSB];
   endfunction

   // WRAP keeps the bits above the (LEN+1)*BYTES window and increments inside it;
   // WRAP with an illegal length and the reserved code fall back to INCR.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [7:0] len,
                                                       input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] incr;
      logic [ADDR_WIDTH-1:0] mask;
      incr = addr + ADDR_WIDTH'(BYTES);
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << LSB) - ADDR_WIDTH'(1);
      if (burst == 2'b00)
         return addr;
      if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         return (addr & ~mask) | (incr & mask);
      return incr;
   endfunction

   assign w_fire      = WVALID & WREADY;
   assign w_last_beat = (w_beat == w_len);
   assign beat_decerr = ~in_range(w_addr);
   assign beat_slverr = (WLAST != w_last_beat);
   assign r_next      = next_addr(r_addr, r_len, r_burst);

   // Write channel FSM: address capture, beat acceptance with sticky errors, response.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_state  <= W_IDLE;
         AWREADY  <= 1'b0;
         WREADY   <= 1'b0;
         BVALID   <= 1'b0;
         BID      <= '0;
         BRESP    <= 2'b00;
         w_addr   <= '0;
         w_len    <= '0;
         w_burst  <= 2'b00;
         w_beat   <= '0;
         w_decerr <= 1'b0;
         w_slverr <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (AWVALID && AWREADY) begin
                  w_addr   <= AWADDR;
                  w_len    <= AWLEN;
                  w_burst  <= AWBURST;
                  BID      <= AWID;
                  w_beat   <= '0;
                  w_decerr <= 1'b0;
                  w_slverr <= 1'b0;
                  AWREADY  <= 1'b0;
                  WREADY   <= 1'b1;
                  w_state  <= W_DATA;
               end else begin
                  AWREADY  <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  w_addr   <= next_addr(w_addr, w_len, w_burst);
                  w_beat   <= w_beat + 8'd1;
                  w_decerr <= w_decerr | beat_decerr;
                  w_slverr <= w_slverr | beat_slverr;
                  if (w_last_beat) begin
                     WREADY  <= 1'b0;
                     BVALID  <= 1'b1;
                     BRESP   <= (w_decerr | beat_decerr) ? 2'b11 :
                                (w_slverr | beat_slverr) ? 2'b10 : 2'b00;
                     w_state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  BVALID  <= 1'b0;
                  AWREADY <= 1'b1;
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Memory write port: strobed byte lanes of in-range beats; contents survive reset.
   always_ff @(posedge ACLK) begin
      if (w_fire && in_range(w_addr)) begin
         for (int b = 0; b < BYTES; b++) begin
            if (WSTRB[b])
               mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
         end
      end
   end

   // Read channel FSM: RDATA is preloaded at capture and reloaded on every handshake,
   // so a same-cycle write to the word being reloaded is not visible in that beat.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= R_IDLE;
         ARREADY <= 1'b0;
         RVALID  <= 1'b0;
         RLAST   <= 1'b0;
         RDATA   <= '0;
         RID     <= '0;
         RRESP   <= 2'b00;
         r_addr  <= '0;
         r_len   <= '0;
         r_burst <= 2'b00;
         r_beat  <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ARVALID && ARREADY) begin
                  r_addr  <= ARADDR;
                  r_len   <= ARLEN;
                  r_burst <= ARBURST;
                  RID     <= ARID;
                  r_beat  <= '0;
                  RVALID  <= 1'b1;
                  RLAST   <= (ARLEN == 8'd0);
                  RDATA   <= in_range(ARADDR) ? mem[word_idx(ARADDR)] : '0;
                  RRESP   <= in_range(ARADDR) ? 2'b00 : 2'b11;
                  ARREADY <= 1'b0;
                  r_state <= R_DATA;
               end else begin
                  ARREADY <= 1'b1;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  if (RLAST) begin
                     RVALID  <= 1'b0;
                     RLAST   <= 1'b0;
                     ARREADY <= 1'b1;
                     r_state <= R_IDLE;
                  end else begin
                     r_addr  <= r_next;
                     r_beat  <= r_beat + 8'd1;
                     RLAST   <= ((r_beat + 8'd1) == r_len);
                     RDATA   <= in_range(r_next) ? mem[word_idx(r_next)] : '0;
                     RRESP   <= in_range(r_next) ? 2'b00 : 2'b11;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// tb_axi4_mem_responder: directed and randomized bursts against a word-level memory model.
module tb_axi4_mem_responder;
   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        AWVALID, AWREADY;
   logic [63:0] AWADDR;
   logic [7:0]  AWLEN;
   logic [1:0]  AWBURST;
   logic [29:0] AWID;
   logic        WVALID, WREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   logic        BVALID, BREADY;
   logic [29:0] BID;
   logic [1:0]  BRESP;
   logic        ARVALID, ARREADY;
   logic [63:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [1:0]  ARBURST;
   logic [29:0] ARID;
   logic        RVALID, RREADY;
   logic [31:0] RDATA;
   logic [29:0] RID;
   logic [1:0]  RRESP;
   logic        RLAST;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] ref_mem [1024];

   axi4_mem_responder dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
      .AWBURST(AWBURST), .AWID(AWID),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
      .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
      .ARBURST(ARBURST), .ARID(ARID),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID), .RRESP(RRESP),
      .RLAST(RLAST)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input logic [63:0] a);
      return a[63:12] == 52'd0;
   endfunction

   function automatic logic [9:0] widx(input logic [63:0] a);
      return a[11:2];
   endfunction

   // Byte address of beat i, straight from the burst definitions.
   function automatic logic [63:0] beat_addr(input logic [63:0] start, input int len,
                                             input logic [1:0] burst, input int i);
      logic [63:0] size, base;
      if (burst == 2'b00) return start;
      if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
         size = 64'((len + 1) * 4);
         base = start - (start % size);
         return base + ((start - base + 64'(i * 4)) % size);
      end
      return start + 64'(i * 4);
   endfunction

   task automatic do_write(input logic [63:0] addr, input int len, input logic [1:0] burst,
                           input logic [29:0] id, input int bad, input bit given,
                           input logic [31:0] d0, input bit rnd_strb, input logic [3:0] strb0);
      logic [63:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        dec, slv, lst;
      logic [1:0]  exp_resp;
      int          t, k;
      dec = 1'b0;
      slv = 1'b0;
      @(negedge ACLK);
      AWVALID = 1'b1; AWADDR = addr; AWLEN = 8'(len); AWBURST = burst; AWID = id;
      t = 0;
      while (AWREADY !== 1'b1 && t < 50) begin @(negedge ACLK); t++; end
      chk("aw_ready", 64'(AWREADY), 64'd1);
      @(posedge ACLK);
      @(negedge ACLK);
      AWVALID = 1'b0;
      chk("w_ready_latency", 64'(WREADY), 64'd1);
      for (int i = 0; i <= len; i++) begin
         a   = beat_addr(addr, len, burst, i);
         d   = given ? d0 + 32'(i) : $urandom;
         s   = rnd_strb ? 4'($urandom) : strb0;
         lst = (i == len) ^ (i == bad);
         if ($urandom_range(0, 4) == 0) begin
            WVALID = 1'b0;
            @(negedge ACLK);
         end
         WVALID = 1'b1; WDATA = d; WSTRB = s; WLAST = lst;
         chk("w_ready", 64'(WREADY), 64'd1);
         @(posedge ACLK);
         if (in_rng(a)) begin
            for (int b = 0; b < 4; b++)
               if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
         end else begin
            dec = 1'b1;
         end
         if (lst != (i == len)) slv = 1'b1;
         @(negedge ACLK);
      end
      WVALID = 1'b0; WLAST = 1'b0;
      exp_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
      chk("b_valid_latency", 64'(BVALID), 64'd1);
      chk("w_ready_drop", 64'(WREADY), 64'd0);
      chk("b_id", 64'(BID), 64'(id));
      chk("b_resp", 64'(BRESP), 64'(exp_resp));
      k = $urandom_range(0, 2);
      for (int c = 0; c < k; c++) begin
         @(negedge ACLK);
         chk("b_hold_valid", 64'(BVALID), 64'd1);
         chk("b_hold_resp", 64'(BRESP), 64'(exp_resp));
      end
      BREADY = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
      BREADY = 1'b0;
      chk("b_valid_clear", 64'(BVALID), 64'd0);
      chk("aw_ready_return", 64'(AWREADY), 64'd1);
   endtask

   task automatic do_read(input logic [63:0] addr, input int len, input logic [1:0] burst,
                          input logic [29:0] id, input int stall_beat, input int stall_n,
                          input bit rnd_stall);
      logic [63:0] a;
      logic [31:0] ed;
      logic [1:0]  er;
      logic        el;
      int          t, n;
      @(negedge ACLK);
      ARVALID = 1'b1; ARADDR = addr; ARLEN = 8'(len); ARBURST = burst; ARID = id;
      t = 0;
      while (ARREADY !== 1'b1 && t < 50) begin @(negedge ACLK); t++; end
      chk("ar_ready", 64'(ARREADY), 64'd1);
      @(posedge ACLK);
      @(negedge ACLK);
      ARVALID = 1'b0;
      for (int i = 0; i <= len; i++) begin
         a  = beat_addr(addr, len, burst, i);
         ed = in_rng(a) ? ref_mem[widx(a)] : 32'd0;
         er = in_rng(a) ? 2'b00 : 2'b11;
         el = (i == len);
         chk("r_valid", 64'(RVALID), 64'd1);
         chk("r_data", 64'(RDATA), 64'(ed));
         chk("r_resp", 64'(RRESP), 64'(er));
         chk("r_last", 64'(RLAST), 64'(el));
         chk("r_id", 64'(RID), 64'(id));
         n = (i == stall_beat) ? stall_n : (rnd_stall ? $urandom_range(0, 1) : 0);
         if (n > 0) RREADY = 1'b0;
         for (int c = 0; c < n; c++) begin
            @(negedge ACLK);
            chk("r_hold_valid", 64'(RVALID), 64'd1);
            chk("r_hold_data", 64'(RDATA), 64'(ed));
            chk("r_hold_resp", 64'(RRESP), 64'(er));
            chk("r_hold_last", 64'(RLAST), 64'(el));
            chk("r_hold_id", 64'(RID), 64'(id));
         end
         RREADY = 1'b1;
         @(posedge ACLK);
         @(negedge ACLK);
      end
      RREADY = 1'b0;
      chk("r_valid_clear", 64'(RVALID), 64'd0);
      chk("ar_ready_return", 64'(ARREADY), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_awready"}, 64'(AWREADY), 64'd0);
      chk({tag, "_wready"},  64'(WREADY),  64'd0);
      chk({tag, "_bvalid"},  64'(BVALID),  64'd0);
      chk({tag, "_arready"}, 64'(ARREADY), 64'd0);
      chk({tag, "_rvalid"},  64'(RVALID),  64'd0);
      chk({tag, "_rlast"},   64'(RLAST),   64'd0);
      chk({tag, "_bid"},     64'(BID),     64'd0);
      chk({tag, "_bresp"},   64'(BRESP),   64'd0);
      chk({tag, "_rid"},     64'(RID),     64'd0);
      chk({tag, "_rresp"},   64'(RRESP),   64'd0);
      chk({tag, "_rdata"},   64'(RDATA),   64'd0);
   endtask

   initial begin
      logic [63:0] ra;
      int          rl, bad;
      logic [1:0]  rb;
      ARESETn = 1'b0;
      AWVALID = 1'b0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWID = '0;
      WVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; BREADY = 1'b0;
      ARVALID = 1'b0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARID = '0; RREADY = 1'b0;

      // Reset values and ready rise one edge after release.
      @(posedge ACLK);
      #2;
      chk_reset_outputs("reset");
      @(negedge ACLK);
      ARESETn = 1'b1;
      #1;
      chk("aw_ready_pre_edge", 64'(AWREADY), 64'd0);
      @(negedge ACLK);
      chk("aw_ready_post_release", 64'(AWREADY), 64'd1);
      chk("ar_ready_post_release", 64'(ARREADY), 64'd1);

      // Fill the whole memory so every later read has a known model value.
      for (int q = 0; q < 4; q++)
         do_write(64'(q * 1024), 255, 2'b01, 30'(q), -1, 1'b0, 32'd0, 1'b0, 4'hF);

      // INCR write then read-back.
      do_write(64'h10, 3, 2'b01, 30'h1234567, -1, 1'b1, 32'hA0, 1'b0, 4'hF);
      do_read(64'h10, 3, 2'b01, 30'h2AAAAAAA, -1, 0, 1'b0);

      // WRAP read: 0x08, 0x0C, 0x00, 0x04.
      do_read(64'h08, 3, 2'b10, 30'h15, -1, 0, 1'b0);

      // Byte strobes.
      do_write(64'h40, 0, 2'b01, 30'h7, -1, 1'b1, 32'hFFFFFFFF, 1'b0, 4'hF);
      do_write(64'h40, 0, 2'b01, 30'h8, -1, 1'b1, 32'h12345678, 1'b0, 4'h3);
      chk("strobe_model", 64'(ref_mem[16]), 64'hFFFF5678);
      do_read(64'h40, 0, 2'b01, 30'h9, -1, 0, 1'b0);

      // Errors: out-of-range write, early WLAST, missing WLAST, out-of-range read.
      do_write(64'h1000, 0, 2'b01, 30'h3FFFFFFF, -1, 1'b1, 32'hDEADBEEF, 1'b0, 4'hF);
      do_read(64'h0, 3, 2'b01, 30'h1, -1, 0, 1'b0);
      do_write(64'h80, 1, 2'b01, 30'h21, 0, 1'b1, 32'hC0, 1'b0, 4'hF);
      do_write(64'h90, 2, 2'b01, 30'h22, 2, 1'b1, 32'hD0, 1'b0, 4'hF);
      do_read(64'h1000, 1, 2'b01, 30'h23, -1, 0, 1'b0);

      // Backpressure: RREADY low for 3 cycles mid-burst.
      do_read(64'h20, 7, 2'b01, 30'h31, 2, 3, 1'b0);

      // FIXED burst, and INCR wrapping through the top of the address space.
      do_write(64'h104, 3, 2'b00, 30'h41, -1, 1'b1, 32'hF00, 1'b0, 4'hF);
      do_read(64'h104, 2, 2'b00, 30'h42, -1, 0, 1'b0);
      do_read(64'hFFFF_FFFF_FFFF_FFF8, 3, 2'b01, 30'h43, -1, 0, 1'b0);

      // Reset mid-read, before the first R handshake.
      @(negedge ACLK);
      ARVALID = 1'b1; ARADDR = 64'h200; ARLEN = 8'd3; ARBURST = 2'b01; ARID = 30'h55;
      @(posedge ACLK);
      @(negedge ACLK);
      ARVALID = 1'b0;
      chk("rst_read_started", 64'(RVALID), 64'd1);
      #2;
      ARESETn = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      @(negedge ACLK);
      ARESETn = 1'b1;
      #1;
      chk("ar_ready_pre_edge", 64'(ARREADY), 64'd0);
      @(negedge ACLK);
      chk("ar_ready_after_reset", 64'(ARREADY), 64'd1);
      do_read(64'h200, 3, 2'b01, 30'h56, -1, 0, 1'b0);

      // Randomized bursts with random strobes, burst types and occasional errors.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0) ra = {32'($urandom), 32'($urandom)};
         else ra = 64'($urandom_range(0, 4095));
         rl  = $urandom_range(0, 15);
         rb  = 2'($urandom_range(0, 3));
         bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, rl) : -1;
         if ($urandom_range(0, 1) == 0)
            do_write(ra, rl, rb, 30'($urandom), bad, 1'b0, 32'd0, 1'b1, 4'h0);
         else
            do_read(ra, rl, rb, 30'($urandom), -1, 0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
